exec_step_ctrl: RTL and testbench
=================================

Name: exec_step_ctrl

Overview:
Execution sequencer for the single-cycle processor in computer_top. It drives the CPU clock-enable so the core either single-steps once per debounced button press or free-runs at a divided rate. Execution halts on a PC breakpoint or when PC reaches a program-end limit. It sits between the button debouncer (one-cycle pulse) and the core's PC/register-file enables.

Parameters:
PC_W, 32, width of PC and breakpoint address
PC_LIMIT, 32'h0000_0140, PC value at or above which execution stops permanently
RUN_DIV, 4, clk cycles per enable in RUN mode (>=1; 1 = enable every cycle)
CNT_W, 16, width of executed-instruction counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
btn_pulse  in  1  one-cycle debounced button pulse
run_sw  in  1  1 = free-run mode, 0 = single-step mode
pc  in  PC_W  current PC of core (address about to execute)
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint address
cpu_en  out  1  core enable; core commits exactly one instruction per clk with cpu_en=1
halted  out  1  1 while in HALT
halt_cause  out  2  0 NONE, 1 BKPT, 2 LIMIT, 3 SELF
state_o  out  2  current state (debug)
instr_count  out  CNT_W  instructions enabled since reset

Behaviour:
- Reset (async): state IDLE, cpu_en=0, halted=0, halt_cause=NONE, instr_count=0, prescaler=0, skip_bp=0.
- States: IDLE, STEP, RUN, HALT.
- Pre-execution check `stop`, evaluated combinationally on current pc whenever an enable is about to issue:
  - LIMIT if pc >= PC_LIMIT (unsigned).
  - BKPT if bp_en && pc==bp_addr && !skip_bp.
  - LIMIT has priority over BKPT.
- cpu_en is combinational from state and counters, and is never high in the same cycle as `stop`.
- IDLE:
  - run_sw=1 → RUN (prescaler cleared). run_sw takes priority; a btn_pulse in the same cycle is dropped.
  - btn_pulse && !run_sw → STEP.
- STEP (one cycle):
  - if stop: cpu_en=0, go to HALT, latch cause.
  - else: cpu_en=1, instr_count++, clear skip_bp, go to IDLE.
  - Latency: btn_pulse at cycle N → cpu_en at N+1.
- RUN:
  - Prescaler counts 0..RUN_DIV-1 and wraps.
  - Enable slot when prescaler==RUN_DIV-1. In that slot: if stop → HALT, else cpu_en=1, instr_count++, clear skip_bp.
  - run_sw=0 → IDLE next cycle; no enable in that cycle. btn_pulse is ignored in RUN.
- HALT:
  - cpu_en=0, halted=1.
  - btn_pulse with cause BKPT (or SELF) → set skip_bp, clear halted/cause, go to STEP if run_sw=0, else RUN. Resuming executes the breakpoint instruction once.
  - Cause LIMIT is sticky until reset; btn_pulse is ignored.
- instr_count saturates at all-ones; no wrap.
- Reset mid-RUN or mid-STEP: cpu_en drops immediately (async) and state returns to IDLE.

Optional Feature:
SELF_LOOP_HALT_EN:
- Defined: the block registers the pc present at each enable. In the cycle after an enable, if pc equals that registered value (branch-to-self, e.g. final `b .`), go to HALT with cause SELF; no further enable issues. SELF is resumable like BKPT.
- Undefined: no PC history register, cause 3 is never produced, and a self-loop runs indefinitely in RUN.

Decomposition:
- Package exec_ctrl_pkg: state enum (IDLE, STEP, RUN, HALT), halt_cause enum (NONE, BKPT, LIMIT, SELF), encoding widths.
- Sub-module run_prescaler: modulo-RUN_DIV counter with clear input and `tick` output, used only in RUN.
- Stop logic and FSM stay in the top.

Test Plan:
1. Reset, run_sw=0, pc=0x00, three btn_pulse 50 cycles apart → exactly three single-cycle cpu_en pulses, each one cycle after its btn_pulse; instr_count=3.
2. run_sw=1, RUN_DIV=4, pc advancing +4 per enable → cpu_en every 4th cycle; run_sw→0 → IDLE next cycle with no further enables.
3. bp_en=1, bp_addr=0x20, RUN from 0x00 → eight enables, then halted=1, halt_cause=BKPT, pc held at 0x20. btn_pulse → exactly one enable at 0x20, then RUN resumes.
4. pc reaches 0x140 in RUN → HALT with cause LIMIT and no enable at 0x140. btn_pulse ignored; only reset clears it.
5. btn_pulse and run_sw rising in the same IDLE cycle → RUN entered, no STEP enable issued. Reset asserted mid-RUN → cpu_en=0 in the same cycle.
6. (SELF_LOOP_HALT_EN) pc stays 0x3C after an enable → HALT with cause SELF on the following cycle. Without the macro, enables continue.

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
// Shared types for the execution sequencer: FSM states, halt causes and
// the helper that decides whether a halt may be resumed by the button.
package exec_ctrl_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned CAUSE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_BKPT  = 2'd1,
        CAUSE_LIMIT = 2'd2,
        CAUSE_SELF  = 2'd3
    } cause_t;

    // LIMIT is terminal; every other halt can be stepped past.
    function automatic logic cause_resumable(input cause_t c);
        return (c == CAUSE_BKPT) || (c == CAUSE_SELF);
    endfunction

endpackage

// File: rtl/exec_step_ctrl_run_prescaler.sv
// Modulo-RUN_DIV prescaler for free-run mode. Held at zero while clr is
// high; tick marks the last count of each period while counting.
module run_prescaler #(
    parameter int unsigned RUN_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(RUN_DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..RUN_DIV-1 and wrap; clear has priority over counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/exec_step_ctrl.sv
// Execution sequencer: single-steps the core once per button pulse or
// free-runs it at a divided rate, halting on PC breakpoint or PC limit.
// Optional macro SELF_LOOP_HALT_EN adds a branch-to-self halt (cause SELF).
module exec_step_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned        PC_W     = 32,
    parameter logic [PC_W-1:0]    PC_LIMIT = PC_W'(32'h0000_0140),
    parameter int unsigned        RUN_DIV  = 4,
    parameter int unsigned        CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_pulse,
    input  logic             run_sw,
    input  logic [PC_W-1:0]  pc,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    output logic             cpu_en,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state;
    cause_t           cause;
    logic             halted_r;
    logic             skip_bp;
    logic [CNT_W-1:0] count;

    logic   tick;
    logic   limit_hit;
    logic   bkpt_hit;
    logic   self_hit;
    logic   stop;
    cause_t stop_cause;
    logic   slot;
    logic   halt_req;
    cause_t halt_cause_nxt;

    run_prescaler #(
        .RUN_DIV (RUN_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (state != ST_RUN),
        .en    (state == ST_RUN),
        .tick  (tick)
    );

`ifdef SELF_LOOP_HALT_EN
    logic [PC_W-1:0] last_pc;
    logic            en_d;

    // Remember the pc of each committed instruction for branch-to-self detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_pc <= '0;
            en_d    <= 1'b0;
        end else begin
            en_d <= cpu_en;
            if (cpu_en) begin
                last_pc <= pc;
            end
        end
    end

    assign self_hit = en_d && (pc == last_pc);
`else
    assign self_hit = 1'b0;
`endif

    assign limit_hit = (pc >= PC_LIMIT);
    assign bkpt_hit  = bp_en && (pc == bp_addr) && !skip_bp;
    assign stop      = limit_hit || bkpt_hit || self_hit;

    // Halt cause priority: LIMIT over BKPT over SELF.
    always_comb begin
        stop_cause = CAUSE_NONE;
        if (limit_hit) begin
            stop_cause = CAUSE_LIMIT;
        end else if (bkpt_hit) begin
            stop_cause = CAUSE_BKPT;
        end else if (self_hit) begin
            stop_cause = CAUSE_SELF;
        end
    end

    // An enable slot exists in STEP, or in RUN on the prescaler tick while still running.
    assign slot   = (state == ST_STEP) || ((state == ST_RUN) && run_sw && tick);
    assign cpu_en = slot && !stop;

    // Decide whether this cycle sends the FSM to HALT and with which cause.
    // A self-loop seen outside an enable slot still halts, so the next slot never issues.
    always_comb begin
        halt_req       = 1'b0;
        halt_cause_nxt = CAUSE_NONE;
        if (slot) begin
            if (stop) begin
                halt_req       = 1'b1;
                halt_cause_nxt = stop_cause;
            end
        end else if ((state == ST_IDLE || state == ST_RUN) && self_hit) begin
            halt_req       = 1'b1;
            halt_cause_nxt = CAUSE_SELF;
        end
    end

    // Main sequencer FSM with registered status outputs and instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cause    <= CAUSE_NONE;
            halted_r <= 1'b0;
            skip_bp  <= 1'b0;
            count    <= '0;
        end else begin
            if (cpu_en) begin
                skip_bp <= 1'b0;
                if (count != '1) begin
                    count <= count + CNT_W'(1);
                end
            end
            if (halt_req) begin
                state    <= ST_HALT;
                cause    <= halt_cause_nxt;
                halted_r <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (run_sw) begin
                            state <= ST_RUN;
                        end else if (btn_pulse) begin
                            state <= ST_STEP;
                        end
                    end
                    ST_STEP: begin
                        state <= ST_IDLE;
                    end
                    ST_RUN: begin
                        if (!run_sw) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_HALT: begin
                        if (btn_pulse && cause_resumable(cause)) begin
                            skip_bp  <= 1'b1;
                            halted_r <= 1'b0;
                            cause    <= CAUSE_NONE;
                            state    <= run_sw ? ST_RUN : ST_STEP;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign halted      = halted_r;
    assign halt_cause  = cause;
    assign state_o     = state;
    assign instr_count = count;

endmodule

// File: tb/tb_exec_step_ctrl.sv
// Directed self-checking bench for exec_step_ctrl: a table of single-step
// stop-check vectors followed by hand-written multi-cycle sequences.
module tb_exec_step_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_pulse;
    logic        run_sw;
    logic [31:0] pc;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic        cpu_en;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [1:0]  state_o;
    logic [15:0] instr_count;

    int   n_checks = 0;
    int   n_err    = 0;
    int   n_en     = 0;
    logic auto_pc  = 1'b0;

    always #5 clk = ~clk;

    exec_step_ctrl #(
        .PC_W     (32),
        .PC_LIMIT (32'h0000_0140),
        .RUN_DIV  (4),
        .CNT_W    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_pulse   (btn_pulse),
        .run_sw      (run_sw),
        .pc          (pc),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .cpu_en      (cpu_en),
        .halted      (halted),
        .halt_cause  (halt_cause),
        .state_o     (state_o),
        .instr_count (instr_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic        bp_en;
        logic [31:0] bp_addr;
        logic        exp_en;
        logic [1:0]  exp_cause;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample cpu_en mid-cycle, and model the core advancing pc on commit.
    task automatic cyc();
        logic en;
        @(negedge clk);
        en = cpu_en;
        @(posedge clk);
        #1;
        if (en) begin
            n_en++;
            if (auto_pc) pc = pc + 32'd4;
        end
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        btn_pulse = 1'b0;
        run_sw    = 1'b0;
        bp_en     = 1'b0;
        bp_addr   = '0;
        auto_pc   = 1'b0;
        pc        = '0;
        cyc();
        reset = 1'b0;
        n_en  = 0;
    endtask

    task automatic pulse();
        btn_pulse = 1'b1;
        cyc();
        btn_pulse = 1'b0;
    endtask

    task automatic run_until_halt(input int budget, input string name);
        int k = 0;
        while (!halted && k < budget) begin
            cyc();
            k++;
        end
        chk(name, halted, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        vecs[0] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 2'd0};
        vecs[1] = '{32'h0000_0020, 1'b1, 32'h0000_0020, 1'b0, 2'd1};
        vecs[2] = '{32'h0000_0020, 1'b1, 32'h0000_0024, 1'b1, 2'd0};
        vecs[3] = '{32'h0000_0020, 1'b0, 32'h0000_0020, 1'b1, 2'd0};
        vecs[4] = '{32'h0000_013C, 1'b0, 32'h0000_0000, 1'b1, 2'd0};
        vecs[5] = '{32'h0000_0140, 1'b0, 32'h0000_0000, 1'b0, 2'd2};
        vecs[6] = '{32'h0000_0140, 1'b1, 32'h0000_0140, 1'b0, 2'd2};
        vecs[7] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1'b0, 2'd2};
        vecs[8] = '{32'h8000_0000, 1'b0, 32'h0000_0000, 1'b0, 2'd2};

        // Reset state while reset is held.
        reset = 1'b1; btn_pulse = 1'b0; run_sw = 1'b0; bp_en = 1'b0; bp_addr = '0; pc = '0;
        #12;
        chk("reset cpu_en", cpu_en, 0);
        chk("reset halted", halted, 0);
        chk("reset cause", halt_cause, 0);
        chk("reset state", state_o, 0);
        chk("reset count", instr_count, 0);

        // Table: one single-step from a fixed pc through the stop check.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            pc      = vecs[i].pc;
            bp_en   = vecs[i].bp_en;
            bp_addr = vecs[i].bp_addr;
            pulse();
            chk($sformatf("vec%0d cpu_en", i), cpu_en, vecs[i].exp_en);
            cyc();
            chk($sformatf("vec%0d cause", i), halt_cause, vecs[i].exp_cause);
            chk($sformatf("vec%0d halted", i), halted, vecs[i].exp_en ? 0 : 1);
            chk($sformatf("vec%0d state", i), state_o, vecs[i].exp_en ? 0 : 3);
            chk($sformatf("vec%0d count", i), instr_count, vecs[i].exp_en);
        end

        // Three single steps, 50 cycles apart.
        do_reset();
        auto_pc = 1'b1;
        for (int p = 0; p < 3; p++) begin
            base = n_en;
            pulse();
            chk($sformatf("step%0d en next cycle", p), cpu_en, 1);
            repeat (49) cyc();
            chk($sformatf("step%0d single enable", p), n_en - base, 1);
        end
        chk("step count", instr_count, 3);
        chk("step pc", pc, 32'h0C);

        // Free-run at RUN_DIV=4, then leave RUN.
        do_reset();
        auto_pc = 1'b1;
        run_sw  = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk($sformatf("run en k%0d", k), cpu_en, (k % 4 == 0) ? 1 : 0);
        end
        cyc();
        run_sw = 1'b0;
        base   = n_en;
        cyc();
        chk("run exit state", state_o, 0);
        repeat (10) cyc();
        chk("run exit no enables", n_en - base, 0);
        chk("run count", instr_count, 3);
        chk("run pc", pc, 32'h0C);

        // Breakpoint at 0x20 in RUN, then resume.
        do_reset();
        auto_pc = 1'b1;
        bp_en   = 1'b1;
        bp_addr = 32'h20;
        run_sw  = 1'b1;
        run_until_halt(100, "bkpt halt reached");
        chk("bkpt enables", n_en, 8);
        chk("bkpt cause", halt_cause, 1);
        chk("bkpt pc", pc, 32'h20);
        chk("bkpt state", state_o, 3);
        chk("bkpt count", instr_count, 8);
        pulse();
        base = n_en;
        repeat (4) cyc();
        chk("bkpt resume one enable", n_en - base, 1);
        chk("bkpt resume pc", pc, 32'h24);
        chk("bkpt resume halted", halted, 0);
        repeat (8) cyc();
        chk("bkpt resume continues", n_en - base, 3);
        chk("bkpt resume state", state_o, 2);

        // PC limit reached in RUN: sticky until reset.
        do_reset();
        auto_pc = 1'b1;
        pc      = 32'h130;
        run_sw  = 1'b1;
        run_until_halt(100, "limit halt reached");
        chk("limit enables", n_en, 4);
        chk("limit cause", halt_cause, 2);
        chk("limit pc", pc, 32'h140);
        base = n_en;
        pulse();
        repeat (10) cyc();
        chk("limit sticky halted", halted, 1);
        chk("limit sticky cause", halt_cause, 2);
        chk("limit no enable", n_en - base, 0);
        run_sw = 1'b0;
        pulse();
        repeat (5) cyc();
        chk("limit sticky state", state_o, 3);
        reset = 1'b1;
        #1;
        chk("limit reset halted", halted, 0);
        chk("limit reset cause", halt_cause, 0);
        reset = 1'b0;

        // run_sw and btn_pulse together; reset in the middle of an enable slot.
        do_reset();
        auto_pc   = 1'b1;
        run_sw    = 1'b1;
        btn_pulse = 1'b1;
        cyc();
        btn_pulse = 1'b0;
        chk("both run state", state_o, 2);
        chk("both no step en", cpu_en, 0);
        base = n_en;
        repeat (3) cyc();
        chk("both no early enable", n_en - base, 0);
        chk("both slot en", cpu_en, 1);
        reset = 1'b1;
        #1;
        chk("async reset cpu_en", cpu_en, 0);
        chk("async reset state", state_o, 0);
        reset = 1'b0;

`ifdef SELF_LOOP_HALT_EN
        // Branch-to-self halts the cycle after its enable; resumable.
        do_reset();
        pc = 32'h3C;
        pulse();
        chk("self step en", cpu_en, 1);
        cyc();
        chk("self idle state", state_o, 0);
        chk("self idle en", cpu_en, 0);
        cyc();
        chk("self halted", halted, 1);
        chk("self cause", halt_cause, 3);
        chk("self state", state_o, 3);
        base = n_en;
        pulse();
        chk("self resume en", cpu_en, 1);
        cyc();
        cyc();
        chk("self rehalt", halted, 1);
        chk("self rehalt cause", halt_cause, 3);
        chk("self resume one enable", n_en - base, 1);
`else
        // Without the self-loop halt a fixed pc keeps running.
        do_reset();
        pc     = 32'h3C;
        run_sw = 1'b1;
        repeat (24) cyc();
        chk("selfloop not halted", halted, 0);
        chk("selfloop enables", n_en, 5);
        chk("selfloop count", instr_count, 5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
